// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions for the MAC transmit/receive pair.
// Contents: FSM state encoding, framing byte constants, CRC-32 constants,
// header field lengths, counter widths and the address-filter helper.
package eth_pkg;

  // Frame parser/generator states; 3-bit encoding shared with the transmitter.
  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    DEST,
    SRC,
    TYPE,
    PAYLOAD,
    FCS,
    DONE
  } eth_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [47:0] BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;

  localparam int unsigned DEST_BYTES = 6;
  localparam int unsigned SRC_BYTES  = 6;
  localparam int unsigned TYPE_BYTES = 2;
  localparam int unsigned FCS_BYTES  = 4;

  // Byte counter covers the longest field; preamble counter saturates at 15.
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PRE_W = 4;
  localparam logic [PRE_W-1:0] PRE_CNT_MAX = '1;

  // Destination filter: promiscuous, own station address, or broadcast.
  function automatic logic addr_accepted(input logic [47:0] dest,
                                         input logic [47:0] station,
                                         input logic        promisc);
    return promisc || (dest == station) || (dest == BROADCAST_ADDR);
  endfunction

endpackage

// File: rtl/frame_reception_if.sv
// Byte-stream receive bus plus parsed-frame result bus.
// Signals: rx_data/rx_valid (PHY byte stream into the receiver);
// payload_out, dest_addr, src_addr, eth_type (captured fields);
// frame_valid, crc_err, frame_err (1-cycle status pulses); busy.
// Modports: master = PHY/host side, slave = frame receiver.
interface frame_reception_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] payload_out;
  logic [47:0] dest_addr;
  logic [47:0] src_addr;
  logic [15:0] eth_type;
  logic        frame_valid;
  logic        crc_err;
  logic        frame_err;
  logic        busy;

  modport master (
    output rx_data, rx_valid,
    input  payload_out, dest_addr, src_addr, eth_type,
    input  frame_valid, crc_err, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output payload_out, dest_addr, src_addr, eth_type,
    output frame_valid, crc_err, frame_err, busy
  );

endinterface

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 byte update (reflected, LSB-first).
// Ports: crc_in - current CRC register, data - next byte,
//        crc_c  - CRC register after absorbing data.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_c
);

  // Eight serial LFSR steps unrolled; bit 0 of the byte enters first.
  always_comb begin
    crc_c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_c[0] ^ data[i]) begin
        crc_c = (crc_c >> 1) ^ CRC_POLY_REFL;
      end else begin
        crc_c = crc_c >> 1;
      end
    end
  end

endmodule

// File: rtl/frame_reception.sv
// Ethernet frame receiver: hunts preamble/SFD, parses destination, source,
// EtherType, a fixed-length payload and the FCS, and reports the outcome.
// Ports: clk, rst (synchronous, active-high);
//        bus (slave) - rx_data/rx_valid in; captured fields, status pulses
//        (frame_valid, crc_err, frame_err) and busy out, all registered.
module frame_reception
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR      = 48'hFFFF_FFFF_FFFF,
  parameter bit          PROMISC       = 1'b0,
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned MIN_PREAMBLE  = 7
) (
  input logic              clk,
  input logic              rst,
  frame_reception_if.slave bus
);

  localparam logic [CNT_W-1:0] DEST_LAST = CNT_W'(DEST_BYTES - 1);
  localparam logic [CNT_W-1:0] SRC_LAST  = CNT_W'(SRC_BYTES - 1);
  localparam logic [CNT_W-1:0] TYPE_LAST = CNT_W'(TYPE_BYTES - 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] FCS_LAST  = CNT_W'(FCS_BYTES - 1);
  localparam logic [PRE_W-1:0] MIN_PRE   = PRE_W'(MIN_PREAMBLE);

  eth_state_e       state;
  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [31:0]      crc_q;
  logic [31:0]      payload_q;
  logic [47:0]      dest_q;
  logic [47:0]      src_q;
  logic [15:0]      type_q;
  logic             frame_valid_q;
  logic             crc_err_q;
  logic             frame_err_q;
  logic             busy_q;

  logic [31:0]      crc_c;
  logic             in_frame_c;
  logic             is_pre_c;

  crc32_d8 u_crc (
    .crc_in (crc_q),
    .data   (bus.rx_data),
    .crc_c  (crc_c)
  );

  assign in_frame_c = state inside {DEST, SRC, TYPE, PAYLOAD, FCS};
  assign is_pre_c   = bus.rx_valid && (bus.rx_data == PREAMBLE_BYTE);

  // Payload is packed MSB-first: byte k lands in lane 3-k.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

  // Receive FSM with registered fields, status pulses and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pre_cnt       <= '0;
      byte_cnt      <= '0;
      crc_q         <= CRC_INIT;
      payload_q     <= '0;
      dest_q        <= '0;
      src_q         <= '0;
      type_q        <= '0;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;

      if (in_frame_c && !bus.rx_valid) begin
        // Stream gap inside a frame: abandon it and flag a framing error.
        state       <= IDLE;
        byte_cnt    <= '0;
        frame_err_q <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        if (in_frame_c) begin
          crc_q    <= crc_c;
          byte_cnt <= byte_cnt + CNT_W'(1);
        end

        case (state)
          IDLE: begin
            if (is_pre_c) begin
              state   <= HUNT;
              pre_cnt <= PRE_W'(1);
            end
          end

          HUNT: begin
            if (is_pre_c) begin
              if (pre_cnt != PRE_CNT_MAX) begin
                pre_cnt <= pre_cnt + PRE_W'(1);
              end
            end else if (bus.rx_valid && (bus.rx_data == SFD_BYTE) &&
                         (pre_cnt >= MIN_PRE)) begin
              state     <= DEST;
              byte_cnt  <= '0;
              crc_q     <= CRC_INIT;
              payload_q <= '0;
              busy_q    <= 1'b1;
            end else begin
              // Short preamble, wrong byte or gap: drop back silently.
              state <= IDLE;
            end
          end

          DEST: begin
            dest_q <= {dest_q[39:0], bus.rx_data};
            if (byte_cnt == DEST_LAST) begin
              state    <= SRC;
              byte_cnt <= '0;
            end
          end

          SRC: begin
            src_q <= {src_q[39:0], bus.rx_data};
            if (byte_cnt == SRC_LAST) begin
              state    <= TYPE;
              byte_cnt <= '0;
            end
          end

          TYPE: begin
            type_q <= {type_q[7:0], bus.rx_data};
            if (byte_cnt == TYPE_LAST) begin
              state    <= PAYLOAD;
              byte_cnt <= '0;
            end
          end

          PAYLOAD: begin
            payload_q <= put_byte(payload_q, byte_cnt[1:0], bus.rx_data);
            if (byte_cnt == PAY_LAST) begin
              state    <= FCS;
              byte_cnt <= '0;
            end
          end

          FCS: begin
            if (byte_cnt == FCS_LAST) begin
              // Outcome is decided on the last FCS byte so the pulse is
              // visible during DONE.
              state    <= DONE;
              byte_cnt <= '0;
              if (crc_c == CRC_RESIDUE) begin
                frame_valid_q <= addr_accepted(dest_q, MAC_ADDR, PROMISC);
              end else begin
                crc_err_q <= 1'b1;
              end
            end
          end

          DONE: begin
            busy_q   <= 1'b0;
            byte_cnt <= '0;
            if (is_pre_c) begin
              state   <= HUNT;
              pre_cnt <= PRE_W'(1);
            end else begin
              state <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.payload_out = payload_q;
  assign bus.dest_addr   = dest_q;
  assign bus.src_addr    = src_q;
  assign bus.eth_type    = type_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = busy_q;

endmodule
